uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter feeding NREQ character sources into one UART transmitter.
// Optional busy_tx watchdog enabled by defining UART_TX_ARB_TIMEOUT_EN. Rev 1.0
`default_nettype none

module uart_tx_arbiter #(
  parameter int DWIDTH  = 8,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DWIDTH-1:0]   req_data,
  input  logic [NREQ-1:0]          req_par_en,
  input  logic [NREQ-1:0]          req_par_type,
  output logic [NREQ-1:0]          req_ready,
  output logic [DWIDTH-1:0]        p_data_tx,
  output logic                     data_valid_tx,
  output logic                     parity_en_tx,
  output logic                     parity_type_tx,
  input  logic                     busy_tx,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     arb_busy,
  output logic                     err_timeout
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  state_e              state_q;
  logic [IW-1:0]       rr_ptr_q;
  logic [IW-1:0]       rr_ptr_d;
  logic [DWIDTH-1:0]   p_data_q;
  logic                data_valid_q;
  logic                par_en_q;
  logic                par_type_q;
  logic [IW-1:0]       grant_id_q;
  logic                arb_busy_q;

  logic                win_vld;
  logic [IW-1:0]       win_idx;
  logic [DWIDTH-1:0]   win_data;
  logic                xfer;
  int                  j;

  // Search upward from rr_ptr with wrap-around; first valid requester wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!win_vld && req_valid[j]) begin
        win_vld = 1'b1;
        win_idx = IW'(j);
      end
    end
  end

  assign win_data  = req_data[int'(win_idx)*DWIDTH +: DWIDTH];
  assign rr_ptr_d  = (win_idx == IW'(NREQ-1)) ? '0 : win_idx + 1'b1;
  assign xfer      = rst && (state_q == IDLE) && !busy_tx && win_vld;
  assign req_ready = xfer ? (NREQ'(1) << win_idx) : '0;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT+1);
  logic [CW-1:0] cnt_q;
  logic          err_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_en_q     <= 1'b0;
      par_type_q   <= 1'b0;
      grant_id_q   <= '0;
      arb_busy_q   <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      cnt_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      data_valid_q <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      err_q        <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (xfer) begin
            p_data_q     <= win_data;
            par_en_q     <= req_par_en[win_idx];
            par_type_q   <= req_par_type[win_idx];
            grant_id_q   <= win_idx;
            rr_ptr_q     <= rr_ptr_d;
            data_valid_q <= 1'b1;
            arb_busy_q   <= 1'b1;
            state_q      <= ISSUE;
`ifdef UART_TX_ARB_TIMEOUT_EN
            cnt_q        <= '0;
`endif
          end
        end
        ISSUE: begin
          state_q <= WAIT_BUSY;
`ifdef UART_TX_ARB_TIMEOUT_EN
          cnt_q   <= cnt_q + 1'b1;
`endif
        end
        WAIT_BUSY: begin
          if (busy_tx) begin
            state_q <= WAIT_DONE;
          end
`ifdef UART_TX_ARB_TIMEOUT_EN
          // Count includes the ISSUE cycle, so expiry lands TIMEOUT cycles after ISSUE.
          else if (cnt_q == CW'(TIMEOUT-1)) begin
            err_q      <= 1'b1;
            arb_busy_q <= 1'b0;
            state_q    <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        WAIT_DONE: begin
          if (!busy_tx) begin
            arb_busy_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
  generate
    if (TIMEOUT < 1) begin : g_timeout_unused
    end
  endgenerate
`endif

  assign p_data_tx      = p_data_q;
  assign data_valid_tx  = data_valid_q;
  assign parity_en_tx   = par_en_q;
  assign parity_type_tx = par_type_q;
  assign grant_id       = grant_id_q;
  assign arb_busy       = arb_busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NREQ=4, DWIDTH=8, TIMEOUT=16).
`default_nettype none

module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_par_en, req_par_type, req_ready;
  logic [31:0] req_data;
  logic [7:0]  p_data_tx;
  logic        data_valid_tx, parity_en_tx, parity_type_tx, busy_tx;
  logic [1:0]  grant_id;
  logic        arb_busy, err_timeout;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.DWIDTH(8), .NREQ(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data),
    .req_par_en(req_par_en), .req_par_type(req_par_type),
    .req_ready(req_ready), .p_data_tx(p_data_tx),
    .data_valid_tx(data_valid_tx), .parity_en_tx(parity_en_tx),
    .parity_type_tx(parity_type_tx), .busy_tx(busy_tx),
    .grant_id(grant_id), .arb_busy(arb_busy), .err_timeout(err_timeout)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Transmitter model: starting in the ISSUE cycle, raise busy for nb cycles, end in IDLE.
  task automatic finish_frame(input int nb);
    tick(); busy_tx = 1'b1;
    repeat (nb) tick();
    busy_tx = 1'b0; tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; busy_tx = 1'b0; req_valid = 4'h0; req_data = '0;
    req_par_en = 4'h0; req_par_type = 4'h0;
    #3;
    n_cmp++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    n_cmp++; if (p_data_tx !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", p_data_tx); end
    n_cmp++; if ({data_valid_tx, parity_en_tx, parity_type_tx, arb_busy, err_timeout} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 00000", {data_valid_tx, parity_en_tx, parity_type_tx, arb_busy, err_timeout}); end
    n_cmp++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_gid: got %0d want 0", grant_id); end
    tick(); tick();
    rst = 1'b1; tick();
  endtask

  task automatic test_round_robin();
    int id;
    req_data = 32'h4332_2110; req_par_en = 4'b1010; req_par_type = 4'b0110;
    req_valid = 4'hF; #1;
    for (int k = 0; k < 5; k++) begin
      id = k % 4;
      n_cmp++; if (req_ready !== 4'(1 << id)) begin n_fail++; $display("FAIL rr_ready k=%0d: got %b want %b", k, req_ready, 4'(1 << id)); end
      tick();
      if (k == 4) req_valid = 4'h0;
      n_cmp++; if (grant_id !== 2'(id)) begin n_fail++; $display("FAIL rr_gid k=%0d: got %0d want %0d", k, grant_id, id); end
      n_cmp++; if (p_data_tx !== 8'(8'h10 + 8'h11 * id)) begin n_fail++; $display("FAIL rr_data k=%0d: got %h want %h", k, p_data_tx, 8'(8'h10 + 8'h11 * id)); end
      n_cmp++; if ({data_valid_tx, parity_en_tx, parity_type_tx} !== {1'b1, req_par_en[id], req_par_type[id]}) begin
        n_fail++; $display("FAIL rr_issue k=%0d: got %b want %b", k, {data_valid_tx, parity_en_tx, parity_type_tx}, {1'b1, req_par_en[id], req_par_type[id]}); end
      tick(); busy_tx = 1'b1;
      n_cmp++; if ({req_ready, data_valid_tx} !== 5'b0) begin n_fail++; $display("FAIL rr_quiet k=%0d: got %b want 00000", k, {req_ready, data_valid_tx}); end
      repeat (10) tick();
      n_cmp++; if (p_data_tx !== 8'(8'h10 + 8'h11 * id)) begin n_fail++; $display("FAIL rr_hold k=%0d: got %h want %h", k, p_data_tx, 8'(8'h10 + 8'h11 * id)); end
      busy_tx = 1'b0; tick();
    end
  endtask

  task automatic test_single();
    req_data = 32'h00A5_0000; req_par_en = 4'b0100; req_par_type = 4'b0100;
    req_valid = 4'b0100; #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    tick(); req_valid = 4'h0;
    n_cmp++; if ({data_valid_tx, parity_en_tx, parity_type_tx, arb_busy} !== 4'b1111) begin
      n_fail++; $display("FAIL single_flags: got %b want 1111", {data_valid_tx, parity_en_tx, parity_type_tx, arb_busy}); end
    n_cmp++; if (p_data_tx !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", p_data_tx); end
    n_cmp++; if (grant_id !== 2'd2) begin n_fail++; $display("FAIL single_gid: got %0d want 2", grant_id); end
    n_cmp++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL single_ready_once: got %b want 0000", req_ready); end
    tick();
    n_cmp++; if (data_valid_tx !== 1'b0) begin n_fail++; $display("FAIL single_dv_pulse: got %b want 0", data_valid_tx); end
    busy_tx = 1'b1; repeat (3) tick(); busy_tx = 1'b0; tick();
    n_cmp++; if (arb_busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got %b want 0", arb_busy); end
  endtask

  task automatic test_wrap();
    req_data = 32'h0000_5AC3; req_par_en = 4'h0; req_par_type = 4'h0;
    req_valid = 4'b0011; #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL wrap_ready0: got %b want 0001", req_ready); end
    tick(); req_valid = 4'b0010;
    n_cmp++; if ({grant_id, p_data_tx} !== {2'd0, 8'hC3}) begin n_fail++; $display("FAIL wrap_gid0: got %0d/%h want 0/c3", grant_id, p_data_tx); end
    finish_frame(4);
    n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL wrap_ready1: got %b want 0010", req_ready); end
    tick(); req_valid = 4'h0;
    n_cmp++; if ({grant_id, p_data_tx} !== {2'd1, 8'h5A}) begin n_fail++; $display("FAIL wrap_gid1: got %0d/%h want 1/5a", grant_id, p_data_tx); end
    finish_frame(4);
  endtask

  task automatic test_busy_hold();
    int viol = 0;
    req_data = 32'h0000_003C; req_valid = 4'b0001; #1;
    tick(); tick(); busy_tx = 1'b1; tick();
    repeat (50) begin
      if (req_ready !== 4'h0 || data_valid_tx !== 1'b0) viol++;
      tick();
    end
    n_cmp++; if (viol !== 0) begin n_fail++; $display("FAIL hold_quiet: got %0d violations want 0", viol); end
    busy_tx = 1'b0; #1;
    n_cmp++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL hold_fall_ready: got %b want 0000", req_ready); end
    tick();
    n_cmp++; if ({req_ready, data_valid_tx} !== 5'b0001_0) begin n_fail++; $display("FAIL hold_idle: got %b want 00010", {req_ready, data_valid_tx}); end
    tick(); req_valid = 4'h0;
    n_cmp++; if ({data_valid_tx, grant_id, p_data_tx} !== {1'b1, 2'd0, 8'h3C}) begin
      n_fail++; $display("FAIL hold_reissue: got %b/%0d/%h want 1/0/3c", data_valid_tx, grant_id, p_data_tx); end
    finish_frame(2);
  endtask

  task automatic test_busy_idle();
    req_data = 32'h0000_7700; req_valid = 4'b0010; busy_tx = 1'b1; #1;
    n_cmp++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL busyidle_ready: got %b want 0000", req_ready); end
    tick();
    n_cmp++; if ({arb_busy, data_valid_tx} !== 2'b00) begin n_fail++; $display("FAIL busyidle_nogrant: got %b want 00", {arb_busy, data_valid_tx}); end
    busy_tx = 1'b0; #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL busyidle_release: got %b want 0010", req_ready); end
    tick(); req_valid = 4'h0;
    n_cmp++; if ({data_valid_tx, grant_id, p_data_tx} !== {1'b1, 2'd1, 8'h77}) begin
      n_fail++; $display("FAIL busyidle_issue: got %b/%0d/%h want 1/1/77", data_valid_tx, grant_id, p_data_tx); end
    finish_frame(2);
  endtask

  task automatic test_timeout();
    req_data = 32'h0011_0000; req_valid = 4'b0100; #1;
    tick(); req_valid = 4'h0;
`ifdef UART_TX_ARB_TIMEOUT_EN
    repeat (15) tick();
    n_cmp++; if ({err_timeout, arb_busy} !== 2'b01) begin n_fail++; $display("FAIL to_early: got %b want 01", {err_timeout, arb_busy}); end
    tick();
    n_cmp++; if ({err_timeout, arb_busy} !== 2'b10) begin n_fail++; $display("FAIL to_pulse: got %b want 10", {err_timeout, arb_busy}); end
    tick();
    n_cmp++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL to_oneshot: got %b want 0", err_timeout); end
`else
    repeat (40) tick();
    n_cmp++; if ({err_timeout, arb_busy} !== 2'b01) begin n_fail++; $display("FAIL to_disabled: got %b want 01", {err_timeout, arb_busy}); end
    busy_tx = 1'b1; tick(); busy_tx = 1'b0; tick();
    n_cmp++; if (arb_busy !== 1'b0) begin n_fail++; $display("FAIL to_recover: got %b want 0", arb_busy); end
`endif
  endtask

  task automatic test_reset_midframe();
    req_data = 32'hE700_0000; req_par_en = 4'b1000; req_par_type = 4'b1000;
    req_valid = 4'b1111; #1;
    tick(); tick(); busy_tx = 1'b1; tick();
    #2 rst = 1'b0; #1;
    n_cmp++; if ({p_data_tx, grant_id} !== 10'b0) begin n_fail++; $display("FAIL rstmid_data: got %h/%0d want 00/0", p_data_tx, grant_id); end
    n_cmp++; if ({data_valid_tx, parity_en_tx, parity_type_tx, arb_busy, err_timeout, req_ready} !== 9'b0) begin
      n_fail++; $display("FAIL rstmid_flags: got %b want 000000000", {data_valid_tx, parity_en_tx, parity_type_tx, arb_busy, err_timeout, req_ready}); end
    busy_tx = 1'b0; tick();
    rst = 1'b1; #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rstmid_ready: got %b want 0001", req_ready); end
    tick(); req_valid = 4'h0;
    n_cmp++; if ({data_valid_tx, grant_id, p_data_tx} !== {1'b1, 2'd0, 8'h00}) begin
      n_fail++; $display("FAIL rstmid_grant: got %b/%0d/%h want 1/0/00", data_valid_tx, grant_id, p_data_tx); end
    finish_frame(2);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_wrap();
    test_busy_hold();
    test_busy_idle();
    test_timeout();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
